// File: rtl/transpose_tile_scheduler_pkg.sv
// Shared constants and FSM encoding for the tile transpose scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package transpose_tile_scheduler_pkg;

    localparam int TILE_DIM    = 8;
    localparam int DEFAULT_DIM = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_WAIT_TP = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/transpose_tile_scheduler_tile_addr_gen.sv
// Tile (r,c) walker with source/destination address accumulators and last-tile flag.
// Latency: addresses update the cycle after load/advance.
// Backpressure: none; it only moves when the scheduler pulses advance.
module tile_addr_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [DIM_WIDTH-1:0]  row_tiles,
    input  logic [DIM_WIDTH-1:0]  col_tiles,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  last
);

    localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic [DIM_WIDTH-1:0]  r_q, r_d, c_q, c_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, dst_row_q, dst_row_d;
    logic                  col_end;

    assign col_end  = (c_q == cols_q - DIM_ONE);
    assign last     = col_end && (r_q == rows_q - DIM_ONE);
    assign src_addr = src_q;
    assign dst_addr = dst_q;

    // Destination walks down a column (+R); at a row wrap it restarts one tile past the previous row start.
    always_comb begin
        rows_d    = rows_q;
        cols_d    = cols_q;
        r_d       = r_q;
        c_d       = c_q;
        src_d     = src_q;
        dst_d     = dst_q;
        dst_row_d = dst_row_q;
        if (load) begin
            rows_d    = row_tiles;
            cols_d    = col_tiles;
            r_d       = '0;
            c_d       = '0;
            src_d     = src_base;
            dst_d     = dst_base;
            dst_row_d = dst_base;
        end else if (advance) begin
            src_d = src_q + ADDR_ONE;
            if (col_end) begin
                c_d       = '0;
                r_d       = r_q + DIM_ONE;
                dst_row_d = dst_row_q + ADDR_ONE;
                dst_d     = dst_row_q + ADDR_ONE;
            end else begin
                c_d   = c_q + DIM_ONE;
                dst_d = dst_q + ADDR_WIDTH'(rows_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q    <= '0;
            cols_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            dst_row_q <= '0;
        end else begin
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            r_q       <= r_d;
            c_q       <= c_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            dst_row_q <= dst_row_d;
        end
    end

endmodule

// File: rtl/transpose_tile_scheduler.sv
// Issues one tile read, waits for the transposed tile, pairs it with a destination write.
// Latency: 3 cycles + transpose latency + stalls per tile; done one cycle after the last write.
// Backpressure: rd/wr held until ready; tp_ready_out follows wr_ready while writing.
module transpose_tile_scheduler
    import transpose_tile_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [ADDR_WIDTH-1:0]  cfg_src_base,
    input  logic [ADDR_WIDTH-1:0]  cfg_dst_base,
    input  logic [DIM_WIDTH-1:0]   cfg_row_tiles,
    input  logic [DIM_WIDTH-1:0]   cfg_col_tiles,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [2*DIM_WIDTH-1:0] tiles_done,
    output logic                   rd_req_valid,
    input  logic                   rd_req_ready,
    output logic [ADDR_WIDTH-1:0]  rd_req_addr,
    input  logic                   tp_valid_out,
    output logic                   tp_ready_out,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ADDR_WIDTH-1:0]  wr_addr
);

    sched_state_e           state_q, state_d;
    logic                   err_flag_q, err_flag_d;
    logic [2*DIM_WIDTH-1:0] tiles_done_q, tiles_done_d;
    logic                   ag_load, ag_advance, ag_last;
    logic                   zero_dim;

    assign zero_dim   = (cfg_row_tiles == '0) || (cfg_col_tiles == '0);
    assign tiles_done = tiles_done_q;

    tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .advance   (ag_advance),
        .src_base  (cfg_src_base),
        .dst_base  (cfg_dst_base),
        .row_tiles (cfg_row_tiles),
        .col_tiles (cfg_col_tiles),
        .src_addr  (rd_req_addr),
        .dst_addr  (wr_addr),
        .last      (ag_last)
    );

    always_comb begin
        state_d      = state_q;
        err_flag_d   = err_flag_q;
        tiles_done_d = tiles_done_q;
        ag_load      = 1'b0;
        ag_advance   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        rd_req_valid = 1'b0;
        tp_ready_out = 1'b0;
        wr_valid     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    ag_load      = 1'b1;
                    tiles_done_d = '0;
                    err_flag_d   = zero_dim;
                    state_d      = zero_dim ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                busy         = 1'b1;
                rd_req_valid = 1'b1;
                if (rd_req_ready) state_d = ST_WAIT_TP;
            end
            ST_WAIT_TP: begin
                busy = 1'b1;
                if (tp_valid_out) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // The transpose unit's output handshake is the buffer write handshake.
                busy         = 1'b1;
                wr_valid     = tp_valid_out;
                tp_ready_out = wr_ready;
                if (tp_valid_out && wr_ready) begin
                    tiles_done_d = tiles_done_q + 1'b1;
                    ag_advance   = 1'b1;
                    state_d      = ag_last ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                err     = err_flag_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            err_flag_q   <= 1'b0;
            tiles_done_q <= '0;
        end else begin
            state_q      <= state_d;
            err_flag_q   <= err_flag_d;
            tiles_done_q <= tiles_done_d;
        end
    end

endmodule

// File: tb/tb_transpose_tile_scheduler.sv
// Self-checking bench: vector table plus random jobs against an arithmetic tile-order model.
// Latency/backpressure exercised via random ready and transpose delay.
module tb_transpose_tile_scheduler;
    import transpose_tile_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_src_base = '0, cfg_dst_base = '0;
    logic [7:0]  cfg_row_tiles = '0, cfg_col_tiles = '0;
    logic        busy, done, err;
    logic [15:0] tiles_done;
    logic        rd_req_valid, rd_req_ready = 1'b1;
    logic [15:0] rd_req_addr;
    logic        tp_valid_out = 1'b0, tp_ready_out;
    logic        wr_valid, wr_ready = 1'b1;
    logic [15:0] wr_addr;

    transpose_tile_scheduler #(.ADDR_WIDTH(16), .DIM_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .cfg_row_tiles(cfg_row_tiles), .cfg_col_tiles(cfg_col_tiles),
        .busy(busy), .done(done), .err(err), .tiles_done(tiles_done),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .tp_valid_out(tp_valid_out), .tp_ready_out(tp_ready_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  rows;
        logic [7:0]  cols;
        bit          bp;
        bit          mid;
        int          exp_tiles;
        bit          exp_err;
        logic [15:0] first_wr;
        logic [15:0] last_rd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];
    int done_cnt, err_cnt, vld_cycles, done_cyc, last_wr_cyc;
    bit bp_en = 1'b0;
    bit rd_fire_n = 1'b0, wr_fire_n = 1'b0;
    bit rd_stall_p = 1'b0, wr_stall_p = 1'b0;
    logic [15:0] rd_addr_p, wr_addr_p;
    int tp_cnt = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Buffer and transpose-unit responder: random ready, random 0..3 cycle transpose latency.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            tp_valid_out = 1'b0;
            tp_cnt = -1;
        end else begin
            if (wr_fire_n) tp_valid_out = 1'b0;
            if (rd_fire_n) tp_cnt = $urandom_range(0, 3);
            if (tp_cnt == 0) begin
                tp_valid_out = 1'b1;
                tp_cnt = -1;
            end else if (tp_cnt > 0) begin
                tp_cnt--;
            end
        end
        rd_req_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        wr_ready     = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        rd_fire_n = !rst && rd_req_valid && rd_req_ready;
        wr_fire_n = !rst && wr_valid && wr_ready;
        if (!rst) begin
            if (rd_req_valid || wr_valid) vld_cycles++;
            if (rd_stall_p) check("rd_hold", {15'd0, rd_req_valid, rd_req_addr}, {15'd0, 1'b1, rd_addr_p});
            if (wr_stall_p) check("wr_hold", {16'd0, wr_addr}, {16'd0, wr_addr_p});
            if (rd_fire_n) begin
                check("one_in_flight", rd_q.size(), wr_q.size());
                rd_q.push_back(rd_req_addr);
            end
            if (wr_fire_n) begin
                wr_q.push_back(wr_addr);
                last_wr_cyc = cyc + 1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (err) err_cnt++;
        end
        rd_stall_p = !rst && rd_req_valid && !rd_req_ready;
        wr_stall_p = !rst && wr_valid && !wr_ready;
        rd_addr_p  = rd_req_addr;
        wr_addr_p  = wr_addr;
    end

    task automatic clear_obs();
        rd_q.delete();
        wr_q.delete();
        done_cnt = 0;
        err_cnt = 0;
        vld_cycles = 0;
        done_cyc = -1;
        last_wr_cyc = -2;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int k;
        exp_rd.delete();
        exp_wr.delete();
        for (int r = 0; r < int'(v.rows); r++)
            for (int c = 0; c < int'(v.cols); c++) begin
                exp_rd.push_back(16'(int'(v.src) + r * int'(v.cols) + c));
                exp_wr.push_back(16'(int'(v.dst) + c * int'(v.rows) + r));
            end
        clear_obs();
        bp_en = v.bp;
        @(posedge clk); #1;
        cfg_src_base = v.src; cfg_dst_base = v.dst;
        cfg_row_tiles = v.rows; cfg_col_tiles = v.cols;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        if (v.exp_tiles == 0) check({tag, "_zd_done_err"}, {30'd0, done, err}, 32'd3);
        else                  check({tag, "_start_busy_rdv"}, {30'd0, busy, rd_req_valid}, 32'd3);
        if (v.mid) begin
            repeat (4) @(posedge clk);
            #1;
            cfg_src_base = v.src ^ 16'h5555; cfg_dst_base = v.dst ^ 16'h0F0F;
            cfg_row_tiles = v.rows + 8'd1; cfg_col_tiles = v.cols + 8'd2;
            cfg_start = 1'b1;
            @(posedge clk); #1;
            cfg_start = 1'b0;
        end
        for (k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_err_cnt"}, err_cnt, {31'd0, v.exp_err});
        check({tag, "_tiles_done"}, {16'd0, tiles_done}, v.exp_tiles);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_rd_count"}, rd_q.size(), exp_rd.size());
        check({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), {16'd0, rd_q[i]}, {16'd0, exp_rd[i]});
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), {16'd0, wr_q[i]}, {16'd0, exp_wr[i]});
        if (v.exp_tiles > 0) begin
            if (wr_q.size() > 0) check({tag, "_first_wr"}, {16'd0, wr_q[0]}, {16'd0, v.first_wr});
            if (rd_q.size() > 0) check({tag, "_last_rd"}, {16'd0, rd_q[rd_q.size()-1]}, {16'd0, v.last_rd});
            check({tag, "_done_timing"}, done_cyc, last_wr_cyc);
        end else begin
            check({tag, "_no_vld"}, vld_cycles, 0);
        end
    endtask

    initial begin
        vec_t vecs[7];
        vec_t rv;
        logic [15:0] t1_wr[6];
        int k;
        vecs[0] = '{16'h0100, 16'h0200, 8'd2, 8'd3, 1'b0, 1'b0, 6,  1'b0, 16'h0200, 16'h0105};
        vecs[1] = '{16'h0040, 16'h0080, 8'd1, 8'd1, 1'b1, 1'b0, 1,  1'b0, 16'h0080, 16'h0040};
        vecs[2] = '{16'h0000, 16'h0300, 8'd0, 8'd5, 1'b0, 1'b0, 0,  1'b1, 16'h0000, 16'h0000};
        vecs[3] = '{16'hFFFE, 16'hFFFF, 8'd2, 8'd2, 1'b0, 1'b0, 4,  1'b0, 16'hFFFF, 16'h0001};
        vecs[4] = '{16'h0010, 16'h0500, 8'd3, 8'd2, 1'b1, 1'b1, 6,  1'b0, 16'h0500, 16'h0015};
        vecs[5] = '{16'h1234, 16'h4000, 8'd5, 8'd0, 1'b0, 1'b0, 0,  1'b1, 16'h0000, 16'h0000};
        vecs[6] = '{16'h0000, 16'h0000, 8'd4, 8'd4, 1'b1, 1'b0, 16, 1'b0, 16'h0000, 16'h000F};
        t1_wr = '{16'h0200, 16'h0202, 16'h0204, 16'h0201, 16'h0203, 16'h0205};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {26'd0, busy, done, err, rd_req_valid, tp_ready_out, wr_valid}, 32'd0);
        check("rst_tiles", {16'd0, tiles_done}, 32'd0);
        check("rst_addr", {rd_req_addr, wr_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
            if (i == 0)
                for (int j = 0; j < 6 && j < wr_q.size(); j++)
                    check($sformatf("vec0_wr_lit%0d", j), {16'd0, wr_q[j]}, {16'd0, t1_wr[j]});
            if (i == 3)
                check("vec3_wrap_wr", {wr_q.size() > 3 ? wr_q[2] : 16'hDEAD, wr_q.size() > 3 ? wr_q[3] : 16'hDEAD},
                      {16'h0000, 16'h0002});
        end

        for (int i = 0; i < 6; i++) begin
            rv.src  = 16'($urandom);
            rv.dst  = 16'($urandom);
            rv.rows = 8'($urandom_range(0, 4));
            rv.cols = 8'($urandom_range(0, 4));
            rv.bp   = 1'($urandom_range(0, 1));
            rv.mid  = 1'b0;
            rv.exp_tiles = int'(rv.rows) * int'(rv.cols);
            rv.exp_err   = (rv.rows == 0) || (rv.cols == 0);
            rv.first_wr  = rv.dst;
            rv.last_rd   = 16'(int'(rv.src) + rv.exp_tiles - 1);
            run_job(rv, $sformatf("rnd%0d", i));
        end

        // Reset while the third tile waits on the transpose unit.
        clear_obs();
        bp_en = 1'b0;
        @(posedge clk); #1;
        cfg_src_base = 16'h0A00; cfg_dst_base = 16'h0B00;
        cfg_row_tiles = 8'(DEFAULT_DIM); cfg_col_tiles = 8'(DEFAULT_DIM);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (k = 0; k < 500 && rd_q.size() < 3; k++) @(negedge clk);
        check("rstmid_reached_tile", rd_q.size(), 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_wait_tp", {30'd0, busy, rd_req_valid}, 32'd2);
        @(negedge clk);
        check("rstmid_ctl", {26'd0, busy, done, err, rd_req_valid, tp_ready_out, wr_valid}, 32'd0);
        check("rstmid_tiles", {16'd0, tiles_done}, 32'd0);
        check("rstmid_addr", {rd_req_addr, wr_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(vecs[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
